flipper_motion_controller: RTL
==============================

# flipper_motion_controller

Parametrised next-generation flipper motion controller. It converts left/right key commands, or a ball-tracking target in auto mode, into a per-frame flipper position. Motion uses fixed-point acceleration, friction coast-down, speed saturation, screen-bound clamping and sticky border-collision handling. It sits between the key decoder/collision logic and the flipper drawing object, and supplies `topLeftX`/`topLeftY` to the object and `speedX` to the ball physics.

## Interface
Parameters:
- `INIT_X`, 288: topLeftX after reset/reset_level (pixels)
- `INIT_Y`, 440: constant topLeftY (pixels)
- `FLIPPER_WIDTH`, 64: flipper width (pixels)
- `X_MIN`, 0 / `X_MAX`, 639: leftmost / rightmost drawable pixel
- `ACCEL`, 8: speed increment per frame while driven (fixed-point units)
- `MAX_SPEED`, 256: speed magnitude saturation (fixed-point units)
- `FRICTION`, 4: speed decrement per frame while coasting
- `DEADBAND`, 4: auto-mode tolerance around flipper centre (pixels)

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `startOfFrame` in 1: one-cycle pulse per frame
- `key4IsPressed` / `key6IsPressed` in 1: drive left / right
- `autoMode` in 1: 1 = track `targetX`, 0 = keys
- `targetX` in 11 signed: ball centre X (pixels)
- `pause` in 1: freeze motion
- `reset_level` in 1: synchronous return to initial state
- `collisionFlipperBorderLeft` / `collisionFlipperBorderRight` in 1: border hit pulses
- `topLeftX` out 11 signed: flipper left edge (pixels)
- `topLeftY` out 11 signed: always `INIT_Y`
- `speedX` out 32 signed: current speed, fixed-point (pixels×64 per frame)

## Operation
- Position is held internally as 32-bit signed fixed point, pixel value shifted left by `FIXED_SHIFT` (6). `topLeftX` = position >>> 6 (arithmetic shift, floor).
- Direction command `cmd` ∈ {-1,0,+1}:
  - Manual mode: key4 only gives -1. key6 only gives +1. Both or neither gives 0.
  - Auto mode: centre = topLeftX + WIDTH/2. `targetX` < centre−DEADBAND gives -1. `targetX` > centre+DEADBAND gives +1. Otherwise 0. Keys are ignored.
- States: IDLE (speed 0), DRIVE (cmd≠0), COAST (cmd=0, speed≠0). Evaluated at each update:
  - cmd≠0 → DRIVE. If sign(speed) is opposite to cmd, speed becomes 0 this frame (reversal brake). Otherwise speed += cmd×ACCEL, saturated at ±MAX_SPEED.
  - cmd=0 and speed≠0 → COAST. |speed| is reduced by FRICTION, floored at 0. Reaching 0 means IDLE.
  - cmd=0 and speed=0 → IDLE.
- Position update: pos_next = pos + speed_next, using the new speed.
- Bound clamp:
  - pixel < X_MIN gives pos = X_MIN<<6, speed 0, IDLE.
  - pixel > X_MAX−WIDTH+1 (576) gives pos = 576<<6, speed 0, IDLE.
- Collision handling:
  - Left and right collision pulses set sticky flags. The flags are cleared by each startOfFrame edge after being consumed. A pulse in the same cycle as startOfFrame counts for that update.
  - If the left flag is set and speed_next<0: speed 0, position unchanged, IDLE.
  - If the right flag is set and speed_next>0: the same, mirrored.
  - A flag for the direction opposite to motion is ignored.
- Pause: position, speed and state are held. Collision flags are still cleared at startOfFrame.
- Priority: reset > reset_level > pause > frame update.
  - reset_level restores INIT_X, speed 0, IDLE, and clears flags on the next edge.
  - reset_level acts regardless of startOfFrame.

## Timing
- Reset values: topLeftX=INIT_X, topLeftY=INIT_Y, speedX=0, state IDLE, flags 0.
- The update is single-cycle. Registers change on the clock edge where startOfFrame=1. New outputs are visible the cycle after the pulse.
- Between pulses, outputs are stable. Inputs other than collisions are sampled only at the startOfFrame edge.
- Asserting reset mid-frame clears everything immediately, without waiting for a clock edge.

## Structure
- `flipper_pkg` contains:
  - `FIXED_SHIFT`=6
  - `flipper_state_t` enum {IDLE, DRIVE, COAST}
  - `flipper_dir_t` signed 2-bit
- Sub-module `flipper_direction_sel` is combinational. It selects `cmd` from keys or target/centre comparison. The parent holds the state, speed, position and flag registers.

## Test plan
- Reset, then release: topLeftX=288, topLeftY=440, speedX=0. These values are held for 10 frames with no keys pressed.
- key6 held:
  - speedX = 8, 16, 24 … reaching 256 at frame 32 and staying at 256.
  - topLeftX=292 after frame 8 (fixed-point sum 288).
- Release after saturation:
  - speedX drops by 4 per frame and reaches 0 after 64 frames; state IDLE.
  - Pressing key4 while speed is +256 gives speedX=0 on the next frame, then −8.
- key6 held for 300 frames: topLeftX clamps at 576 and speedX=0, with no overshoot in any frame.
- Collision check:
  - Setup: speed −64. A collisionFlipperBorderLeft pulse arrives mid-frame.
  - Next update: speedX=0 and topLeftX unchanged.
  - The same pulse while moving right has no effect.
- autoMode=1, targetX=100, flipper at 288 (centre 320): the flipper drives left, then coasts once centre is within 96..104.
- pause held for 5 frames, then reset_level:
  - During pause, outputs are frozen.
  - After reset_level, topLeftX returns to 288 and speedX to 0 on the next edge.

Source files
------------

// File: rtl/flipper_pkg.sv
// Shared types and constants for the flipper motion controller.
// Positions and speeds are fixed point with FIXED_SHIFT fractional bits.
package flipper_pkg;

    localparam int FIXED_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        COAST = 2'd2
    } flipper_state_t;

    typedef logic signed [1:0] flipper_dir_t;

    localparam flipper_dir_t DIR_LEFT  = 2'b11;
    localparam flipper_dir_t DIR_NONE  = 2'b00;
    localparam flipper_dir_t DIR_RIGHT = 2'b01;

endpackage

// File: rtl/flipper_direction_sel.sv
// Combinational direction selector: the key pair in manual mode, or the
// target-versus-centre comparison with a deadband in auto mode.
module flipper_direction_sel
    import flipper_pkg::*;
#(
    parameter int FLIPPER_WIDTH = 64,
    parameter int DEADBAND      = 4
) (
    input  logic               auto_mode,
    input  logic               key_left,
    input  logic               key_right,
    input  logic signed [10:0] target_x,
    input  logic signed [10:0] top_left_x,
    output flipper_dir_t       cmd
);

    int centre;
    int target;

    always_comb begin
        centre = int'(top_left_x) + FLIPPER_WIDTH / 2;
        target = int'(target_x);
        cmd    = DIR_NONE;
        if (auto_mode) begin
            if (target < centre - DEADBAND) begin
                cmd = DIR_LEFT;
            end else if (target > centre + DEADBAND) begin
                cmd = DIR_RIGHT;
            end
        end else if (key_left && !key_right) begin
            cmd = DIR_LEFT;
        end else if (key_right && !key_left) begin
            cmd = DIR_RIGHT;
        end
    end

endmodule

// File: rtl/flipper_motion_controller.sv
// Per-frame flipper motion: acceleration, friction, saturation, screen
// clamping and sticky border-collision stops, all in fixed point.
module flipper_motion_controller
    import flipper_pkg::*;
#(
    parameter int INIT_X        = 288,
    parameter int INIT_Y        = 440,
    parameter int FLIPPER_WIDTH = 64,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int ACCEL         = 8,
    parameter int MAX_SPEED     = 256,
    parameter int FRICTION      = 4,
    parameter int DEADBAND      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               key4IsPressed,
    input  logic               key6IsPressed,
    input  logic               autoMode,
    input  logic signed [10:0] targetX,
    input  logic               pause,
    input  logic               reset_level,
    input  logic               collisionFlipperBorderLeft,
    input  logic               collisionFlipperBorderRight,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [31:0] speedX
);

    localparam int X_RIGHT  = X_MAX - FLIPPER_WIDTH + 1;
    localparam int INIT_POS = INIT_X * (1 << FIXED_SHIFT);
    localparam int MIN_POS  = X_MIN * (1 << FIXED_SHIFT);
    localparam int MAX_POS  = X_RIGHT * (1 << FIXED_SHIFT);

    flipper_state_t     state_q, state_d;
    logic signed [31:0] pos_q, pos_d;
    logic signed [31:0] speed_q, speed_d;
    logic signed [31:0] speed_cmd, pos_sum, pixel;
    logic               flag_left_q, flag_right_q;
    logic               flag_left_eff, flag_right_eff;
    flipper_dir_t       cmd;

    assign topLeftX = 11'(pos_q >>> FIXED_SHIFT);
    assign topLeftY = 11'(INIT_Y);
    assign speedX   = speed_q;

    flipper_direction_sel #(
        .FLIPPER_WIDTH (FLIPPER_WIDTH),
        .DEADBAND      (DEADBAND)
    ) u_direction_sel (
        .auto_mode  (autoMode),
        .key_left   (key4IsPressed),
        .key_right  (key6IsPressed),
        .target_x   (targetX),
        .top_left_x (topLeftX),
        .cmd        (cmd)
    );

    // A collision pulse arriving on the update edge itself still counts.
    always_comb begin
        flag_left_eff  = flag_left_q | collisionFlipperBorderLeft;
        flag_right_eff = flag_right_q | collisionFlipperBorderRight;
        speed_cmd      = speed_q;

        if (cmd != DIR_NONE) begin
            if ((cmd == DIR_RIGHT && speed_q < 0) || (cmd == DIR_LEFT && speed_q > 0)) begin
                speed_cmd = '0;
            end else if (cmd == DIR_RIGHT) begin
                speed_cmd = (speed_q >= MAX_SPEED - ACCEL) ? MAX_SPEED : speed_q + ACCEL;
            end else begin
                speed_cmd = (speed_q <= ACCEL - MAX_SPEED) ? -MAX_SPEED : speed_q - ACCEL;
            end
        end else if (state_q != IDLE) begin
            if (speed_q > 0) begin
                speed_cmd = (speed_q > FRICTION) ? speed_q - FRICTION : '0;
            end else if (speed_q < 0) begin
                speed_cmd = (speed_q < -FRICTION) ? speed_q + FRICTION : '0;
            end else begin
                speed_cmd = '0;
            end
        end

        pos_sum = pos_q + speed_cmd;
        pixel   = pos_sum >>> FIXED_SHIFT;
        pos_d   = pos_sum;
        speed_d = speed_cmd;
        state_d = IDLE;

        if ((flag_left_eff && speed_cmd < 0) || (flag_right_eff && speed_cmd > 0)) begin
            pos_d   = pos_q;
            speed_d = '0;
        end else if (pixel < X_MIN) begin
            pos_d   = MIN_POS;
            speed_d = '0;
        end else if (pixel > X_RIGHT) begin
            pos_d   = MAX_POS;
            speed_d = '0;
        end else if (cmd != DIR_NONE) begin
            state_d = DRIVE;
        end else if (speed_cmd != 0) begin
            state_d = COAST;
        end
    end

    // Collision flags are consumed by every frame edge, paused or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= INIT_POS;
            speed_q      <= '0;
            flag_left_q  <= 1'b0;
            flag_right_q <= 1'b0;
        end else if (reset_level) begin
            state_q      <= IDLE;
            pos_q        <= INIT_POS;
            speed_q      <= '0;
            flag_left_q  <= 1'b0;
            flag_right_q <= 1'b0;
        end else begin
            if (startOfFrame && !pause) begin
                state_q <= state_d;
                pos_q   <= pos_d;
                speed_q <= speed_d;
            end
            if (startOfFrame) begin
                flag_left_q  <= 1'b0;
                flag_right_q <= 1'b0;
            end else begin
                flag_left_q  <= flag_left_q | collisionFlipperBorderLeft;
                flag_right_q <= flag_right_q | collisionFlipperBorderRight;
            end
        end
    end

endmodule
